// File: rtl/gaussian_row_elim.sv
// gaussian_row_elim
//   One Gaussian elimination step on a row-major fixed-point matrix held in
//   external memory: target[k] -= (factor * pivot[k]) >>> FRAC_W for
//   k = col_start .. N-1. Element (r,k) lives at A_r + (r*N + k)*(DATA_W/8).
//   One element is processed at a time: read pivot, read target, write back.
//
//   Optional build macro: GAUSS_ROW_SATURATE_EN
//     defined   -> the difference saturates to the signed DATA_W range
//     undefined -> the difference wraps (two's-complement truncation)
//
// Ports
//   clock, reset            sole clock, synchronous active-high reset
//   start / busy            call handshake (busy high outside IDLE)
//   done / stall            return handshake (return taken on done && !stall)
//   A_r, pivot_row,
//   target_row, col_start,
//   factor                  call arguments, registered on acceptance
//   avmm_0_rw_*             Avalon-MM master, one request outstanding at most
module gaussian_row_elim #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int N      = 64,
    parameter int ADDR_W = 64,
    parameter int IDX_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                stall,
    input  logic [ADDR_W-1:0]   A_r,
    input  logic [IDX_W-1:0]    pivot_row,
    input  logic [IDX_W-1:0]    target_row,
    input  logic [IDX_W-1:0]    col_start,
    input  logic [DATA_W-1:0]   factor,
    output logic [ADDR_W-1:0]   avmm_0_rw_address,
    output logic [DATA_W/8-1:0] avmm_0_rw_byteenable,
    output logic                avmm_0_rw_read,
    output logic                avmm_0_rw_write,
    output logic [DATA_W-1:0]   avmm_0_rw_writedata,
    input  logic [DATA_W-1:0]   avmm_0_rw_readdata,
    input  logic                avmm_0_rw_waitrequest,
    input  logic                avmm_0_rw_readdatavalid
);

    localparam int BYTES = DATA_W / 8;
    localparam int PW    = 2 * DATA_W;  // full product width
    localparam int DW    = PW + 1;      // difference width, never overflows

`ifdef GAUSS_ROW_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_P, WT_P, RD_T, WT_T, WR, DONE} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  prow_q, trow_q;
    logic [IDX_W-1:0]  k, k_nxt;
    logic [DATA_W-1:0] factor_q, pivot_q;

    logic accept, empty, last_k;
    logic rd_nxt, wr_nxt;

    // In the accept cycle the arguments are not registered yet, so the first
    // address is formed from the ports directly.
    logic [ADDR_W-1:0] base_cur, elem_idx, addr_nxt;
    logic [IDX_W-1:0]  prow_cur, trow_cur, row_nxt;

    assign accept   = start && !busy && (state == IDLE);
    assign empty    = 32'(col_start) >= 32'(N);
    assign last_k   = 32'(k) == 32'(N - 1);

    assign base_cur = (state == IDLE) ? A_r        : base_q;
    assign prow_cur = (state == IDLE) ? pivot_row  : prow_q;
    assign trow_cur = (state == IDLE) ? target_row : trow_q;

    // ---------------- next-state ----------------
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        unique case (state)
            IDLE: if (accept) begin
                k_nxt     = col_start;
                state_nxt = empty ? DONE : RD_P;
            end
            RD_P: if (!avmm_0_rw_waitrequest)  state_nxt = WT_P;
            WT_P: if (avmm_0_rw_readdatavalid) state_nxt = RD_T;
            RD_T: if (!avmm_0_rw_waitrequest)  state_nxt = WT_T;
            WT_T: if (avmm_0_rw_readdatavalid) state_nxt = WR;
            WR: if (!avmm_0_rw_waitrequest) begin
                if (last_k) begin
                    state_nxt = DONE;
                end else begin
                    k_nxt     = k + IDX_W'(1);
                    state_nxt = RD_P;
                end
            end
            DONE: if (!stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs are registered, so they are derived from the next state.
    assign rd_nxt   = (state_nxt == RD_P) || (state_nxt == RD_T);
    assign wr_nxt   = (state_nxt == WR);
    assign row_nxt  = (state_nxt == RD_P) ? prow_cur : trow_cur;
    assign elem_idx = ADDR_W'(row_nxt) * ADDR_W'(N) + ADDR_W'(k_nxt);
    assign addr_nxt = base_cur + elem_idx * ADDR_W'(BYTES);

    // ---------------- arithmetic ----------------
    logic signed [PW-1:0] fac_x, piv_x, prod, prod_sh;
    logic signed [DW-1:0] diff;
    logic                 ovf;
    logic [DATA_W-1:0]    res;

    always_comb begin
        fac_x   = PW'($signed(factor_q));
        piv_x   = PW'($signed(pivot_q));
        prod    = fac_x * piv_x;
        prod_sh = prod >>> FRAC_W;    // floor division by 2^FRAC_W
        diff    = DW'($signed(avmm_0_rw_readdata)) - DW'(prod_sh);
        // Out of range when the bits above the DATA_W sign bit disagree.
        ovf     = !((&diff[DW-1:DATA_W-1]) || !(|diff[DW-1:DATA_W-1]));
        res     = diff[DATA_W-1:0];
        if (SAT_EN && ovf)
            res = diff[DW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                             : {1'b0, {(DATA_W-1){1'b1}}};
    end

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------- datapath / registered outputs ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            k                    <= '0;
            base_q               <= '0;
            prow_q               <= '0;
            trow_q               <= '0;
            factor_q             <= '0;
            pivot_q              <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            avmm_0_rw_read       <= 1'b0;
            avmm_0_rw_write      <= 1'b0;
            avmm_0_rw_address    <= '0;
            avmm_0_rw_byteenable <= '0;
            avmm_0_rw_writedata  <= '0;
        end else begin
            k                    <= k_nxt;
            busy                 <= (state_nxt != IDLE);
            done                 <= (state_nxt == DONE);
            avmm_0_rw_read       <= rd_nxt;
            avmm_0_rw_write      <= wr_nxt;
            avmm_0_rw_byteenable <= (rd_nxt || wr_nxt) ? '1 : '0;
            if (rd_nxt || wr_nxt)
                avmm_0_rw_address <= addr_nxt;
            if (accept) begin
                base_q   <= A_r;
                prow_q   <= pivot_row;
                trow_q   <= target_row;
                factor_q <= factor;
            end
            if (state == WT_P && avmm_0_rw_readdatavalid)
                pivot_q <= avmm_0_rw_readdata;
            if (state == WT_T && avmm_0_rw_readdatavalid)
                avmm_0_rw_writedata <= res;
        end
    end

endmodule

// File: tb/tb_gaussian_row_elim.sv
// Directed bench for gaussian_row_elim (N=4, DATA_W=32, FRAC_W=16).
// A small Avalon-MM slave model with programmable waitrequest length and
// read latency backs a 4x4 word matrix at BASE; row 1 is pivot, row 2 target.
module tb_gaussian_row_elim;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;
    localparam int N      = 4;
    localparam int ADDR_W = 64;
    localparam int IDX_W  = 16;
    localparam logic [63:0] BASE = 64'h1000;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy, done;
    logic              stall = 1'b0;
    logic [ADDR_W-1:0] a_r = BASE;
    logic [IDX_W-1:0]  pivot_row = 16'd1, target_row = 16'd2, col_start = '0;
    logic [DATA_W-1:0] factor = '0;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              read, write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] rdata = '0;
    logic              waitrequest;
    logic              rdv = 1'b0;

    gaussian_row_elim #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N(N),
                        .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .stall(stall), .A_r(a_r), .pivot_row(pivot_row), .target_row(target_row),
        .col_start(col_start), .factor(factor),
        .avmm_0_rw_address(address), .avmm_0_rw_byteenable(byteenable),
        .avmm_0_rw_read(read), .avmm_0_rw_write(write),
        .avmm_0_rw_writedata(writedata), .avmm_0_rw_readdata(rdata),
        .avmm_0_rw_waitrequest(waitrequest), .avmm_0_rw_readdatavalid(rdv));

    always #5 clock = ~clock;

    // ---------------- slave model ----------------
    logic [31:0] mem [0:15];
    logic [31:0] pv [0:3];
    logic [31:0] tv [0:3];
    logic        load = 1'b0;
    int          wait_cyc = 0, rd_lat = 1;
    int          wcnt = 0, tmr = 0;
    logic [31:0] pend = '0;
    int          wr_cnt = 0, rd_cnt = 0, req_cnt = 0, ret_cnt = 0, bad_addr = 0;
    logic [63:0] off;
    logic [3:0]  idx;

    assign off         = address - BASE;
    assign idx         = off[5:2];
    assign waitrequest = (read || write) && (wcnt < wait_cyc);

    always @(posedge clock) begin
        rdv <= 1'b0;
        if (load)
            for (int i = 0; i < 16; i++)
                mem[i] <= (i / 4 == 1) ? pv[i % 4] :
                          (i / 4 == 2) ? tv[i % 4] : (32'hDEAD_0000 | i);
        if (tmr > 0) begin
            tmr <= tmr - 1;
            if (tmr == 1) begin rdv <= 1'b1; rdata <= pend; end
        end
        if ((read || write) && waitrequest) wcnt <= wcnt + 1;
        else if (!(read || write))          wcnt <= 0;
        if ((read || write) && !waitrequest) begin
            wcnt <= 0;
            if (off >= 64'd64 || off[1:0] != 2'b00) begin
                bad_addr <= bad_addr + 1;
            end else if (write) begin
                mem[idx] <= writedata;
                wr_cnt   <= wr_cnt + 1;
            end else begin
                rd_cnt <= rd_cnt + 1;
                pend   <= mem[idx];
                if (rd_lat == 1) begin rdv <= 1'b1; rdata <= mem[idx]; end
                else tmr <= rd_lat - 1;
            end
        end
        if (read || write)  req_cnt <= req_cnt + 1;
        if (done && !stall) ret_cnt <= ret_cnt + 1;
    end

    // Request must hold address/read/write while the slave stalls it.
    int          stab_err = 0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_addr = '0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    always @(negedge clock) begin
        if (prev_hold && !reset &&
            (address != prev_addr || read != prev_rd || write != prev_wr))
            stab_err <= stab_err + 1;
        prev_hold <= (read || write) && waitrequest && !reset;
        prev_addr <= address;
        prev_rd   <= read;
        prev_wr   <= write;
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, act, exp);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 4; i++) begin
            pv[i] = 32'(i + 1) << 16;
            tv[i] = 32'((i + 1) * 10) << 16;
        end
    endtask

    task automatic do_load();
        @(negedge clock); load = 1'b1;
        @(negedge clock); load = 1'b0;
    endtask

    // Issues a call and returns the number of edges from acceptance to done.
    task automatic do_call(input logic [15:0] cs, input logic [31:0] f,
                           output int n, output logic b1);
        @(negedge clock);
        start = 1'b1; col_start = cs; factor = f;
        a_r = BASE; pivot_row = 16'd1; target_row = 16'd2;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        b1 = busy;
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clock); @(negedge clock); n++;
        end
    endtask

    task automatic finish_ret(input string tag);
        stall = 1'b0;
        @(posedge clock); @(negedge clock);
        chk({tag, "_busy_after_ret"}, 64'(busy), 64'd0);
        chk({tag, "_done_after_ret"}, 64'(done), 64'd0);
    endtask

    task automatic chk_row(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
        chk({tag, "_t0"}, 64'(mem[8]),  64'(e0));
        chk({tag, "_t1"}, 64'(mem[9]),  64'(e1));
        chk({tag, "_t2"}, 64'(mem[10]), 64'(e2));
        chk({tag, "_t3"}, 64'(mem[11]), 64'(e3));
    endtask

    int   lat, w0, r0, q0, s0;
    logic b1;
    int   dne;

    initial begin
        // ---- reset values ----
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_read",  64'(read), 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_addr",  address, 64'd0);
        chk("rst_be",    64'(byteenable), 64'd0);
        chk("rst_wdata", 64'(writedata), 64'd0);
        reset = 1'b0;

        // ---- basic step: 2.0 * {1,2,3,4} off {10,20,30,40} ----
        load_basic(); do_load();
        w0 = wr_cnt;
        do_call(16'd0, 32'h0002_0000, lat, b1);
        chk("basic_busy", 64'(b1), 64'd1);
        chk("basic_lat", 64'(lat), 64'd20);
        chk("basic_writes", 64'(wr_cnt - w0), 64'd4);
        chk_row("basic", 32'h0008_0000, 32'h0010_0000, 32'h0018_0000, 32'h0020_0000);
        chk("basic_pivot_kept", 64'(mem[7]), 64'h0004_0000);
        finish_ret("basic");

        // ---- column offset ----
        load_basic(); do_load();
        w0 = wr_cnt;
        do_call(16'd1, 32'h0002_0000, lat, b1);
        chk("offs_lat", 64'(lat), 64'd15);
        chk("offs_writes", 64'(wr_cnt - w0), 64'd3);
        chk_row("offs", 32'h000A_0000, 32'h0010_0000, 32'h0018_0000, 32'h0020_0000);
        finish_ret("offs");

        // ---- backpressure: 3 wait cycles, 4-cycle read latency ----
        load_basic(); do_load();
        wait_cyc = 3; rd_lat = 4;
        w0 = wr_cnt;
        do_call(16'd0, 32'h0002_0000, lat, b1);
        chk("bp_done_seen", 64'(done), 64'd1);
        chk("bp_writes", 64'(wr_cnt - w0), 64'd4);
        chk("bp_stable", 64'(stab_err), 64'd0);
        chk_row("bp", 32'h0008_0000, 32'h0010_0000, 32'h0018_0000, 32'h0020_0000);
        finish_ret("bp");
        wait_cyc = 0; rd_lat = 1;

        // ---- overflow: 0x80000001 - 2.0 leaves the signed range ----
        load_basic();
        pv[3] = 32'h0001_0000; tv[3] = 32'h8000_0001;
        do_load();
        do_call(16'd3, 32'h0002_0000, lat, b1);
        chk("ovf_lat", 64'(lat), 64'd5);
`ifdef GAUSS_ROW_SATURATE_EN
        chk("ovf_sat", 64'(mem[11]), 64'h8000_0000);
`else
        chk("ovf_wrap", 64'(mem[11]), 64'h7FFE_0001);
`endif
        chk("ovf_t2_untouched", 64'(mem[10]), 64'h001E_0000);
        finish_ret("ovf");

        // ---- return stall with ignored start ----
        load_basic(); do_load();
        stall = 1'b1;
        s0 = ret_cnt;
        do_call(16'd0, 32'h0002_0000, lat, b1);
        chk("stall_lat", 64'(lat), 64'd20);
        q0 = req_cnt;
        dne = 0;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; col_start = 16'd0;
            @(posedge clock); @(negedge clock);
            if (done) dne++;
        end
        chk("stall_done_held", 64'(dne), 64'd5);
        stall = 1'b0; start = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("stall_done_drop", 64'(done), 64'd0);
        chk("stall_busy_drop", 64'(busy), 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("stall_no_requeue", 64'(req_cnt - q0), 64'd0);
        chk("stall_one_return", 64'(ret_cnt - s0), 64'd1);

        // ---- col_start == N: no bus traffic, done next cycle ----
        q0 = req_cnt;
        do_call(16'd4, 32'h0002_0000, lat, b1);
        chk("empty_lat", 64'(lat), 64'd0);
        chk("empty_busy", 64'(b1), 64'd1);
        chk("empty_no_bus", 64'(req_cnt - q0), 64'd0);
        finish_ret("empty");

        // ---- reset while waiting for target read data ----
        load_basic(); do_load();
        rd_lat = 4;
        r0 = rd_cnt; w0 = wr_cnt;
        @(negedge clock);
        start = 1'b1; col_start = 16'd0; factor = 32'h0002_0000;
        @(posedge clock); @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 200 && rd_cnt < r0 + 2; i++) begin
            @(posedge clock); @(negedge clock);
        end
        chk("rst_mid_reached", 64'(rd_cnt - r0), 64'd2);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("rst_mid_read",  64'(read), 64'd0);
        chk("rst_mid_write", 64'(write), 64'd0);
        chk("rst_mid_busy",  64'(busy), 64'd0);
        chk("rst_mid_addr",  address, 64'd0);
        chk("rst_mid_wdata", 64'(writedata), 64'd0);
        reset = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        chk("rst_late_ignored", 64'(wr_cnt - w0), 64'd0);
        chk("rst_idle", 64'(busy), 64'd0);
        rd_lat = 1;
        do_call(16'd0, 32'h0002_0000, lat, b1);
        chk("rst_recall_lat", 64'(lat), 64'd20);
        chk_row("rst_recall", 32'h0008_0000, 32'h0010_0000, 32'h0018_0000, 32'h0020_0000);
        finish_ret("rst_recall");

        chk("addr_in_range", 64'(bad_addr), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
